// File: rtl/mem_access_unit.sv
// Load/store access unit: turns decoder access codes into a held memory request,
// builds byte-lane store strobes/data and formats the returned load word.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemW,
    input  logic        MemR,
    input  logic [3:0]  be,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AlignFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  be_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_wmask_reg;
    logic [31:0] read_data_reg;
    logic        align_fault_reg;

    logic        req, is_word, is_half, misaligned;
    logic [3:0]  wmask_next;
    logic [31:0] wdata_next;
    logic [7:0]  rdata_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // 1111 is the word code even though it also looks like a signed halfword.
    assign req        = MemW | MemR;
    assign is_word    = (be == 4'b1111);
    assign is_half    = ~is_word & be[2];
    assign misaligned = is_half & be[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = gi;
            assign wmask_next[gi] = MemW & (is_word |
                                    (is_half ? (be[1] == LANE[1]) : (be[1:0] == LANE)));
            assign wdata_next[8*gi +: 8] = is_word ? WriteData[8*gi +: 8] :
                                           is_half ? WriteData[8*(gi%2) +: 8] :
                                                     WriteData[7:0];
            assign rdata_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rdata_lane[be_reg[1:0]];
    assign half_sel = be_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_fmt = mem_rdata;
        if (be_reg != 4'b1111) begin
            if (be_reg[2])
                load_fmt = {{16{be_reg[3] & half_sel[15]}}, half_sel};
            else
                load_fmt = {{24{be_reg[3] & byte_sel[7]}}, byte_sel};
        end
    end

    always_comb begin
        state_next = state_reg;
        Stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    Stall      = 1'b1;
                    state_next = misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (mem_ready)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            be_reg          <= 4'b0000;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= 32'h0;
            mem_wdata_reg   <= 32'h0;
            mem_wmask_reg   <= 4'b0000;
            read_data_reg   <= 32'h0;
            align_fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req) begin
                if (misaligned) begin
                    align_fault_reg <= 1'b1;
                    read_data_reg   <= 32'h0;
                end else begin
                    be_reg        <= be;
                    mem_we_reg    <= MemW;
                    mem_addr_reg  <= Addr & ~32'h3;
                    mem_wdata_reg <= wdata_next;
                    mem_wmask_reg <= wmask_next;
                end
            end
            if (state_reg == BUSY && mem_ready) begin
                read_data_reg   <= load_fmt;
                align_fault_reg <= 1'b0;
            end
        end
    end

    assign mem_req    = (state_reg == BUSY);
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_wmask  = mem_wmask_reg;
    assign ReadData   = read_data_reg;
    assign AlignFault = align_fault_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model drives per-cycle expectations
// that one negedge compare process checks, plus literal checks of the directed cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset, MemW, MemR, mem_ready;
    logic [3:0]  be;
    logic [31:0] Addr, WriteData, mem_rdata;
    logic [31:0] ReadData, mem_addr, mem_wdata;
    logic        Stall, AlignFault, mem_req, mem_we;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    bit          chk_en = 0, chk_fields = 0;
    logic        exp_stall, exp_req, exp_fault, exp_we;
    logic [31:0] exp_read, exp_addr, exp_wdata;
    logic [3:0]  exp_wmask;

    logic [31:0] snap_addr, snap_wdata, snap_read;
    logic [3:0]  snap_mask;
    logic        snap_we, snap_fault, snap_stall, snap_req1;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .MemW(MemW), .MemR(MemR), .be(be), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .AlignFault(AlignFault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Access model: size in bytes and starting lane derived from the code.
    function automatic int acc_bytes(logic [3:0] b);
        if (b == 4'hF) return 4;
        return b[2] ? 2 : 1;
    endfunction

    function automatic int acc_lane(logic [3:0] b);
        if (b == 4'hF) return 0;
        return b[2] ? 2 * int'(b[1]) : int'(b[1:0]);
    endfunction

    function automatic bit model_misaligned(logic [3:0] b);
        return (acc_bytes(b) == 2) && b[0];
    endfunction

    function automatic logic [3:0] model_mask(logic [3:0] b);
        int n = acc_bytes(b);
        return 4'(((1 << n) - 1) << acc_lane(b));
    endfunction

    function automatic logic [31:0] model_wdata(logic [3:0] b, logic [31:0] wd);
        int n = acc_bytes(b);
        if (n == 4) return wd;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return (wd & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] model_load(logic [3:0] b, logic [31:0] w);
        int n = acc_bytes(b);
        logic [31:0] v, lim;
        if (n == 4) return w;
        v   = (w >> (8 * acc_lane(b))) & ((32'h1 << (8 * n)) - 1);
        lim = 32'h1 << (8 * n - 1);
        if (b[3] && v >= lim) v = v - (lim << 1);
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("Stall", {31'b0, Stall}, {31'b0, exp_stall});
            check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
            check("ReadData", ReadData, exp_read);
            check("AlignFault", {31'b0, AlignFault}, {31'b0, exp_fault});
            if (chk_fields) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
                check("mem_wmask", {28'b0, mem_wmask}, {28'b0, exp_wmask});
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
        #1;
    endtask

    // One access: request at cycle 0, mem_ready raised at cycle k of BUSY.
    task automatic access(input bit w, input bit r, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int k);
        next_cycle();
        MemW = w; MemR = r; be = b; Addr = a; WriteData = wd; mem_rdata = rd; mem_ready = 0;
        exp_stall = 1; exp_req = 0; chk_fields = 0;
        mid_cycle();
        if (model_misaligned(b)) begin
            next_cycle();
            MemW = 0; MemR = 0;
            exp_stall = 0; exp_req = 0; exp_fault = 1; exp_read = 32'h0;
        end else begin
            for (int i = 1; i <= k; i++) begin
                next_cycle();
                mem_ready  = (i == k);
                exp_stall  = 1; exp_req = 1; chk_fields = 1;
                exp_addr   = {a[31:2], 2'b00};
                exp_we     = w;
                exp_wmask  = w ? model_mask(b) : 4'b0000;
                exp_wdata  = model_wdata(b, wd);
                mid_cycle();
                if (i == 1) begin
                    snap_addr = mem_addr; snap_wdata = mem_wdata; snap_mask = mem_wmask;
                    snap_we = mem_we; snap_req1 = mem_req;
                end
            end
            next_cycle();
            mem_ready = 0; MemW = 0; MemR = 0; chk_fields = 0;
            exp_stall = 0; exp_req = 0; exp_fault = 0; exp_read = model_load(b, rd);
        end
        mid_cycle();
        snap_read = ReadData; snap_fault = AlignFault; snap_stall = Stall;
        next_cycle();
        exp_stall = 0;
        mid_cycle();
        $display("txn we=%0b re=%0b be=%b addr=%h wd=%h rd=%h k=%0d -> ReadData=%h AlignFault=%0b",
                 w, r, b, a, wd, rd, k, snap_read, snap_fault);
    endtask

    initial begin
        reset = 1; MemW = 0; MemR = 0; mem_ready = 0;
        be = 4'h0; Addr = 32'h0; WriteData = 32'h0; mem_rdata = 32'h0;
        next_cycle();
        chk_en = 1; chk_fields = 1;
        exp_stall = 0; exp_req = 0; exp_read = 0; exp_fault = 0;
        exp_addr = 0; exp_we = 0; exp_wmask = 0; exp_wdata = 0;
        mid_cycle();
        check("reset_mem_wdata", mem_wdata, 32'h0);
        next_cycle();
        reset = 0;
        mid_cycle();
        $display("txn reset released");

        access(0, 1, 4'b1111, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
        check("ldr_addr", snap_addr, 32'h0000_0104);
        check("ldr_req_c1", {31'b0, snap_req1}, 32'h1);
        check("ldr_read", snap_read, 32'hDEAD_BEEF);

        access(0, 1, 4'b1011, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1);
        check("ldrsb_read", snap_read, 32'hFFFF_FF80);
        access(0, 1, 4'b0011, 32'h0000_0203, 32'h0, 32'h80FF_1234, 2);
        check("ldrb_read", snap_read, 32'h0000_0080);

        access(1, 0, 4'b0110, 32'h0000_0402, 32'h0000_ABCD, 32'h0, 2);
        check("strh_we", {31'b0, snap_we}, 32'h1);
        check("strh_mask", {28'b0, snap_mask}, 32'hC);
        check("strh_wdata", snap_wdata, 32'hABCD_ABCD);

        access(0, 1, 4'b0101, 32'h0000_0501, 32'h0, 32'h1111_2222, 1);
        check("mis_fault", {31'b0, snap_fault}, 32'h1);
        check("mis_stall", {31'b0, snap_stall}, 32'h0);
        check("mis_read", snap_read, 32'h0);

        access(0, 1, 4'b1110, 32'h0000_0602, 32'h0, 32'h9ABC_0000, 2);
        check("ldrsh_read", snap_read, 32'hFFFF_9ABC);
        check("fault_cleared", {31'b0, snap_fault}, 32'h0);
        access(0, 1, 4'b0100, 32'h0000_0600, 32'h0, 32'h9ABC_8765, 1);
        check("ldrh_read", snap_read, 32'h0000_8765);
        access(1, 1, 4'b1111, 32'h0000_0203, 32'h1234_5678, 32'h0, 1);
        check("both_we", {31'b0, snap_we}, 32'h1);
        check("both_mask", {28'b0, snap_mask}, 32'hF);
        check("both_addr", snap_addr, 32'h0000_0200);
        access(1, 0, 4'b1010, 32'h0000_0702, 32'h0000_00C3, 32'h0, 4);
        check("strb_mask", {28'b0, snap_mask}, 32'h4);
        check("strb_wdata", snap_wdata, 32'hC3C3_C3C3);
        access(1, 0, 4'b0111, 32'h0000_0803, 32'hFFFF_FFFF, 32'h0, 1);
        access(0, 1, 4'b0000, 32'h0000_0900, 32'h0, 32'h0000_00A5, 1);

        // Reset during BUSY, with mem_ready arriving after the abandon.
        next_cycle();
        MemR = 1; be = 4'b1111; Addr = 32'h0000_0300; mem_rdata = 32'h1234_5678;
        exp_stall = 1; exp_req = 0;
        mid_cycle();
        next_cycle();
        exp_req = 1; chk_fields = 1; exp_addr = 32'h0000_0300; exp_we = 0; exp_wmask = 0;
        mid_cycle();
        next_cycle();
        reset = 1;
        mid_cycle();
        next_cycle();
        reset = 0; MemR = 0; mem_ready = 1;
        exp_stall = 0; exp_req = 0; exp_read = 0; exp_fault = 0;
        exp_addr = 0; exp_we = 0; exp_wmask = 0;
        mid_cycle();
        check("rst_busy_req", {31'b0, mem_req}, 32'h0);
        next_cycle();
        mem_ready = 0;
        mid_cycle();
        check("rst_busy_read", ReadData, 32'h0);
        chk_fields = 0;
        $display("txn reset during BUSY, late mem_ready ignored");

        access(0, 1, 4'b1111, 32'h0000_0A00, 32'h0, 32'h0BAD_F00D, 1);
        check("recover_read", snap_read, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 MemW  in  1  store request from decoder for current instruction.
REQ-004 MemR  in  1  load request (decoder MemtoReg & RegW for memory ops).
REQ-005 be  in  4  access code from decoder: 1111 word; 00bb byte unsigned, lane bb; 01bb halfword unsigned, lane bb; 10bb byte signed; 11b0 halfword signed.
REQ-006 Addr  in  32  byte address from ALU.
REQ-007 WriteData  in  32  store source register value.
REQ-008 ReadData  out  32  formatted load result, zero/sign extended.
REQ-009 Stall  out  1  holds PC and register writes while an access is outstanding.
REQ-010 AlignFault  out  1  misaligned halfword access flag.
REQ-011 mem_req  out  1  memory request, held until accepted.
REQ-012 mem_we  out  1  1 = write, 0 = read.
REQ-013 mem_addr  out  32  word address, {Addr[31:2],2'b00}.
REQ-014 mem_wdata  out  32  lane-replicated store data.
REQ-015 mem_wmask  out  4  byte write strobes, bit i = byte lane i.
REQ-016 mem_rdata  in  32  memory read word, valid when mem_ready=1.
REQ-017 mem_ready  in  1  memory completion strobe; sampled only in BUSY.

Function
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE, MemW|MemR=1, access aligned: latch mem_addr/mem_we/mem_wdata/mem_wmask, go BUSY, assert mem_req on next cycle.
REQ-020 IDLE, MemW|MemR=1, halfword code with be[0]=1: no memory request, go DONE with AlignFault=1 in DONE, ReadData=0.
REQ-021 MemW and MemR both high: treated as store.
REQ-022 BUSY: mem_req=1 and request fields stable every cycle until mem_ready=1; on mem_ready, latch formatted ReadData, drop mem_req, go DONE.
REQ-023 DONE: one cycle, Stall=0, ReadData/AlignFault valid, then IDLE; request inputs ignored in DONE.
REQ-024 Stall combinational: 1 in IDLE with MemW|MemR=1, 1 in BUSY, 0 in DONE, 0 in IDLE with no request.
REQ-025 Latency: request at cycle 0, mem_req cycles 1..k (mem_ready at cycle k>=1), DONE at cycle k+1; minimum 2 stall cycles.
REQ-026 Store mask: word 1111; byte one-hot at lane be[1:0]; halfword 0011 (be[1]=0) or 1100 (be[1]=1); be[3] ignored for stores.
REQ-027 Store data: word as is; byte WriteData[7:0] replicated x4; halfword WriteData[15:0] replicated x2.
REQ-028 Load: select byte lane be[1:0] or halfword lane be[1] from mem_rdata; be[3]=1 sign extends, be[3]=0 zero extends; word passes unchanged.
REQ-029 Word access ignores Addr[1:0]; mem_wmask=0000 for loads.
REQ-030 ReadData, AlignFault hold last DONE value until next DONE overwrites them (AlignFault cleared on next non-faulting DONE).

Reset
REQ-031 reset=1 forces IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ReadData, AlignFault all 0 after the edge.
REQ-032 reset during BUSY abandons the access; mem_req=0 next cycle; a late mem_ready in IDLE is ignored.
REQ-033 reset has priority over every FSM transition in the same cycle.

Verification
REQ-034 LDR: be=1111, Addr=0x104, mem_rdata=0xDEADBEEF, mem_ready at cycle 3 -> mem_addr=0x104, mem_req cycles 1-3, ReadData=0xDEADBEEF in DONE cycle 4, Stall 0-3.
REQ-035 LDRSB: be=1011, mem_rdata=0x80FF1234 -> ReadData=0xFFFFFF80; same with be=0011 -> 0x00000080.
REQ-036 STRH: be=0110, WriteData=0x0000ABCD -> mem_we=1, mem_wmask=1100, mem_wdata=0xABCDABCD.
REQ-037 Misaligned LDRH be=0101 -> no mem_req, AlignFault=1 and Stall=0 at cycle 1, ReadData=0.
REQ-038 reset at cycle 2 of BUSY with mem_ready at cycle 3 -> mem_req=0 from cycle 3, state IDLE, ReadData=0, no DONE.
